// File: rtl/pwm_core_sched.sv
// Round-robin scheduler sharing one gen_pwm HLS core (ap_ctrl_hs) among NCH channel requesters.
// Optional abort of hung transactions is compiled in with PWM_SCHED_TIMEOUT_EN.

module pwm_sched_lane (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       ack_set,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       ack,
    output logic [7:0] out_q
);
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ack   <= 1'b0;
            out_q <= 8'h00;
        end else begin
            ack <= ack_set;
            if (wr_en) out_q <= wr_data;
        end
    end
endmodule

module pwm_core_sched #(
    parameter int NCH         = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH*32-1:0] ch_freq,
    input  logic [NCH*32-1:0] ch_duty,
    output logic [NCH-1:0]    ch_ack,
    output logic [NCH*8-1:0]  ch_out,
    output logic              ap_start,
    input  logic              ap_done,
    input  logic              ap_idle,
    input  logic              ap_ready,
    output logic [31:0]       core_freq,
    output logic [31:0]       core_duty,
    input  logic [7:0]        core_out,
    input  logic              core_out_vld,
    output logic              busy,
    output logic              timeout_err
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    if (NCH < 1 || NCH > 16 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("pwm_core_sched: NCH must be 1..16 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

    typedef struct packed {
        logic [31:0] freq;
        logic [31:0] duty;
    } core_req_t;

    state_t    state, state_nxt;
    core_req_t core_q;
    logic [IW-1:0] rr_ptr, sel_q, sel_c, idx;
    logic      found, grant, tmo_hit, done_in, active, cap_in;
    logic [7:0] cap_data, fin_data;
    logic      cap_vld, fin_vld;
    logic [NCH-1:0] lane_wr, lane_ack;

    assign core_freq = core_q.freq;
    assign core_duty = core_q.duty;
    assign active    = (state == S_START) || (state == S_WAIT);
    assign cap_in    = active && core_out_vld;

    // A valid arriving on the same edge that finishes the transaction still wins.
    assign fin_vld  = cap_in | cap_vld;
    assign fin_data = cap_in ? core_out : cap_data;

    // First requester after the last-served channel, wrapping.
    always_comb begin
        sel_c = rr_ptr;
        found = 1'b0;
        idx   = rr_ptr;
        for (int k = 1; k <= NCH; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NCH);
            if (!found && ch_req[idx]) begin
                sel_c = idx;
                found = 1'b1;
            end
        end
    end

`ifdef PWM_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
`endif

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (|ch_req && ap_idle) begin
                    grant     = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (ap_ready && ap_done) state_nxt = S_DONE;
                else if (ap_ready)       state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (ap_done) state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
`ifdef PWM_SCHED_TIMEOUT_EN
        if (active && state_nxt != S_DONE && tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            tmo_hit   = 1'b1;
            state_nxt = S_DONE;
        end
`endif
    end

    assign done_in = (state != S_DONE) && (state_nxt == S_DONE);

    always_ff @(posedge HCLK) begin
        if (HRESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ap_start <= 1'b0;
            busy     <= 1'b0;
            rr_ptr   <= IW'(NCH - 1);
            sel_q    <= '0;
            core_q   <= '0;
            cap_data <= 8'h00;
            cap_vld  <= 1'b0;
        end else begin
            ap_start <= (state_nxt == S_START);
            busy     <= (state_nxt != S_IDLE);
            if (grant) begin
                sel_q       <= sel_c;
                core_q.freq <= ch_freq[32*sel_c +: 32];
                core_q.duty <= ch_duty[32*sel_c +: 32];
                cap_vld     <= 1'b0;
            end else if (cap_in) begin
                cap_data <= core_out;
                cap_vld  <= 1'b1;
            end
            if (state == S_DONE) rr_ptr <= sel_q;
        end
    end

`ifdef PWM_SCHED_TIMEOUT_EN
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (grant)       tmo_cnt <= '0;
            else if (active) tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    // Ack and result land together, both visible during the DONE cycle.
    for (genvar i = 0; i < NCH; i++) begin : g_lane
        assign lane_ack[i] = done_in && (sel_q == IW'(i));
        assign lane_wr[i]  = lane_ack[i] && !tmo_hit && fin_vld;

        pwm_sched_lane u_lane (
            .HCLK    (HCLK),
            .HRESET  (HRESET),
            .ack_set (lane_ack[i]),
            .wr_en   (lane_wr[i]),
            .wr_data (fin_data),
            .ack     (ch_ack[i]),
            .out_q   (ch_out[8*i +: 8])
        );
    end

endmodule

// File: tb/tb_pwm_core_sched.sv
// Scoreboard bench for pwm_core_sched: a scripted core model answers ap_start, a monitor pops
// expected grants at each ack.

module tb_pwm_core_sched;
    localparam int NCH = 4;
    localparam int TMO = 16;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic [NCH-1:0]    ch_req;
    logic [NCH*32-1:0] ch_freq, ch_duty;
    logic [NCH-1:0]    ch_ack;
    logic [NCH*8-1:0]  ch_out;
    logic              ap_start, ap_done, ap_idle, ap_ready;
    logic [31:0]       core_freq, core_duty;
    logic [7:0]        core_out;
    logic              core_out_vld, busy, timeout_err;

    always #5 HCLK = ~HCLK;

    pwm_core_sched #(.NCH(NCH), .TIMEOUT_CYC(TMO)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .ch_req(ch_req), .ch_freq(ch_freq), .ch_duty(ch_duty),
        .ch_ack(ch_ack), .ch_out(ch_out), .ap_start(ap_start), .ap_done(ap_done),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .core_freq(core_freq), .core_duty(core_duty),
        .core_out(core_out), .core_out_vld(core_out_vld), .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct {
        int          ch;
        logic [7:0]  out;
        logic [31:0] freq;
        logic [31:0] duty;
        int          lat;
        int          nstart;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] out_model [NCH];
    int         n_chk = 0, n_err = 0;

    int         m_rdy, m_done, m_vld;
    logic [7:0] m_val;
    bit         m_xor;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_core(input int rdy, input int done, input int vld, input logic [7:0] val,
                            input bit xr);
        m_rdy = rdy; m_done = done; m_vld = vld; m_val = val; m_xor = xr;
    endtask

    task automatic push_exp(input int ch, input bit has_out, input logic [7:0] val,
                            input int lat, input int nst);
        exp_t e;
        if (has_out) out_model[ch] = val;
        e.ch = ch; e.out = out_model[ch];
        e.freq = ch_freq[32*ch +: 32]; e.duty = ch_duty[32*ch +: 32];
        e.lat = lat; e.nstart = nst;
        sb.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic drain(input int maxc);
        for (int i = 0; i < maxc && sb.size() > 0; i++) begin
            @(negedge HCLK); #1;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    // Core model: counts cycles from the first ap_start it sees.
    initial begin
        ap_ready = 0; ap_done = 0; core_out = 8'h00; core_out_vld = 0;
        forever begin
            @(negedge HCLK);
            if (!HRESET && ap_start) begin
                for (int c = 0; c < 2000; c++) begin
                    if (c > 0 && (HRESET || ch_ack != '0 || !busy)) break;
                    ap_ready     = (c == m_rdy);
                    ap_done      = (c == m_done);
                    core_out_vld = (c == m_vld);
                    core_out     = (c == m_vld) ? (m_xor ? (m_val ^ core_freq[7:0]) : m_val) : 8'h00;
                    @(negedge HCLK);
                end
                ap_ready = 0; ap_done = 0; core_out_vld = 0; core_out = 8'h00;
            end
        end
    end

    // Monitor
    initial begin
        bit in_txn;
        int st_cnt, lat_cnt;
        in_txn = 0; st_cnt = 0; lat_cnt = 0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                in_txn = 0; st_cnt = 0; lat_cnt = 0;
            end else begin
                if (ap_start && !in_txn) begin
                    in_txn = 1; st_cnt = 0; lat_cnt = 0;
                    if (sb.size() == 0) chk("start_unexp", 64'(ap_start), 64'd0);
                end
                if (in_txn && ap_start) begin
                    st_cnt++;
                    if (sb.size() > 0) begin
                        chk("start_freq", 64'(core_freq), 64'(sb[0].freq));
                        chk("start_duty", 64'(core_duty), 64'(sb[0].duty));
                    end
                end
                if (ch_ack != '0) begin
                    if (sb.size() == 0) chk("ack_unexp", 64'(ch_ack), 64'd0);
                    else begin
                        mon_e = sb.pop_front();
                        chk("ack_ch", 64'(ch_ack), 64'd1 << mon_e.ch);
                        chk("ch_out", 64'(ch_out[8*mon_e.ch +: 8]), 64'(mon_e.out));
                        chk("done_freq", 64'(core_freq), 64'(mon_e.freq));
                        chk("done_duty", 64'(core_duty), 64'(mon_e.duty));
                        chk("latency", 64'(lat_cnt), 64'(mon_e.lat));
                        chk("start_cycles", 64'(st_cnt), 64'(mon_e.nstart));
                    end
                    in_txn = 0;
                end
                if (in_txn) lat_cnt++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        HRESET = 1; ch_req = '0; ap_idle = 1;
        for (int i = 0; i < NCH; i++) begin
            ch_freq[32*i +: 32] = 32'(100 + i);
            ch_duty[32*i +: 32] = 32'(200 + i);
            out_model[i] = 8'h00;
        end
        set_core(0, 1, -1, 8'h00, 0);
        cycles(3);
        chk("rst_start", 64'(ap_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ack", 64'(ch_ack), 64'd0);
        chk("rst_out", 64'(ch_out), 64'd0);
        chk("rst_freq", 64'(core_freq), 64'd0);
        chk("rst_duty", 64'(core_duty), 64'd0);
        chk("rst_tmo", 64'(timeout_err), 64'd0);
        HRESET = 0;
        cycles(2);

        // Round-robin from reset pointer NCH-1: 0,1,2,3,0
        set_core(1, 2, 1, 8'h5A, 1);
        push_exp(0, 1, 8'h5A ^ 8'(100), 3, 2);
        push_exp(1, 1, 8'h5A ^ 8'(101), 3, 2);
        push_exp(2, 1, 8'h5A ^ 8'(102), 3, 2);
        push_exp(3, 1, 8'h5A ^ 8'(103), 3, 2);
        push_exp(0, 1, 8'h5A ^ 8'(100), 3, 2);
        ch_req = 4'b1111;
        drain(60);
        ch_req = '0;
        cycles(4);

        // Single request, check start latency
        ch_freq[64 +: 32] = 32'd1000;
        ch_duty[64 +: 32] = 32'd250;
        set_core(0, 4, 4, 8'hA5, 0);
        push_exp(2, 1, 8'hA5, 5, 1);
        ch_req = 4'b0100;
        @(negedge HCLK); #1;
        chk("start_lat", 64'(ap_start), 64'd1);
        drain(20);
        ch_req = '0;
        cycles(4);
        chk("single_out", 64'(ch_out[23:16]), 64'hA5);

        // ap_ready held off: ap_start holds, capture in WAIT
        set_core(10, 12, 11, 8'h77, 0);
        push_exp(1, 1, 8'h77, 13, 11);
        ch_req = 4'b0010;
        @(negedge HCLK); #1;
        ch_freq[32 +: 32] = 32'hDEAD_0001;
        ch_duty[32 +: 32] = 32'hDEAD_0002;
        drain(30);
        ch_req = '0;
        ch_freq[32 +: 32] = 32'd101;
        ch_duty[32 +: 32] = 32'd201;
        cycles(3);

        // ready+done+vld same cycle
        set_core(3, 3, 3, 8'h3C, 0);
        push_exp(3, 1, 8'h3C, 4, 4);
        ch_req = 4'b1000;
        drain(20);
        ch_req = '0;
        cycles(3);

        // no valid: output kept, ack still pulses
        set_core(0, 2, -1, 8'hFF, 0);
        push_exp(3, 0, 8'h00, 3, 1);
        ch_req = 4'b1000;
        drain(20);
        ch_req = '0;
        cycles(3);

        // core not idle: no grant
        ap_idle = 0;
        ch_req = 4'b0001;
        cycles(5);
        chk("noidle_busy", 64'(busy), 64'd0);
        chk("noidle_start", 64'(ap_start), 64'd0);
        set_core(0, 1, 1, 8'h11, 0);
        push_exp(0, 1, 8'h11, 2, 1);
        ap_idle = 1;
        drain(20);
        ch_req = '0;
        cycles(3);

        // request dropped mid-transaction
        set_core(2, 6, 6, 8'h99, 0);
        push_exp(1, 1, 8'h99, 7, 3);
        ch_req = 4'b0010;
        cycles(3);
        ch_req = '0;
        drain(20);
        cycles(4);

`ifdef PWM_SCHED_TIMEOUT_EN
        set_core(0, 100000, -1, 8'h00, 0);
        push_exp(2, 0, 8'h00, TMO, 1);
        ch_req = 4'b0100;
        drain(40);
        ch_req = '0;
        chk("tmo_err", 64'(timeout_err), 64'd1);
        cycles(5);
        chk("tmo_sticky", 64'(timeout_err), 64'd1);
`else
        chk("tmo_tied", 64'(timeout_err), 64'd0);
`endif

        // reset mid-WAIT
        set_core(0, 50, -1, 8'h00, 0);
        push_exp(0, 0, 8'h00, 51, 1);
        ch_req = 4'b0001;
        cycles(4);
        #1;
        HRESET = 1;
        sb.delete();
        ch_req = '0;
        @(negedge HCLK);
        chk("midrst_start", 64'(ap_start), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_out", 64'(ch_out), 64'd0);
        chk("midrst_ack", 64'(ch_ack), 64'd0);
        @(negedge HCLK);
        chk("midrst_tmo", 64'(timeout_err), 64'd0);
        HRESET = 0;
        for (int i = 0; i < NCH; i++) out_model[i] = 8'h00;
        cycles(3);

        // pointer back at NCH-1: 4'b0110 grants channel 1 first
        set_core(0, 1, 1, 8'h42, 0);
        push_exp(1, 1, 8'h42, 2, 1);
        ch_req = 4'b0110;
        drain(20);
        ch_req = '0;
        cycles(4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
